// File: rtl/trafficlight_pkg.sv
// Shared types and lamp encodings for the two-approach intersection scheduler.
// The PED_WALK state exists only when PED_REQ_EN is defined.
package trafficlight_pkg;

  typedef enum logic [2:0] {
    INIT_RED = 3'd0,
    A_GREEN  = 3'd1,
    A_YELLOW = 3'd2,
    RED_AB   = 3'd3,
    B_GREEN  = 3'd4,
    B_YELLOW = 3'd5,
    RED_BA   = 3'd6
`ifdef PED_REQ_EN
    ,
    PED_WALK = 3'd7
`endif
  } state_t;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

  function automatic logic [2:0] lamp_a(input state_t s);
    case (s)
      A_GREEN:  lamp_a = LAMP_GRN;
      A_YELLOW: lamp_a = LAMP_YEL;
      default:  lamp_a = LAMP_RED;
    endcase
  endfunction

  function automatic logic [2:0] lamp_b(input state_t s);
    case (s)
      B_GREEN:  lamp_b = LAMP_GRN;
      B_YELLOW: lamp_b = LAMP_YEL;
      default:  lamp_b = LAMP_RED;
    endcase
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk into a one-cycle timing tick every TICK_DIV cycles.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/intersection_scheduler.sv
// Demand-driven two-approach traffic light sequencer with min/max green, yellow and all-red timing.
// Optional pedestrian walk phase is enabled by defining PED_REQ_EN.
module intersection_scheduler
  import trafficlight_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 1,
  parameter int unsigned MIN_GREEN = 4,
  parameter int unsigned MAX_GREEN = 10,
  parameter int unsigned YELLOW_T  = 2,
  parameter int unsigned ALLRED_T  = 1,
  parameter int unsigned WALK_T    = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       traffic_A,
  input  logic       traffic_B,
`ifdef PED_REQ_EN
  input  logic       ped_req,
  output logic       walk,
`endif
  output logic [2:0] light_A,
  output logic [2:0] light_B
);

  // Timer must reach the longest dwell plus one for the e = timer+1 compare.
  localparam int unsigned DUR_1 = (MAX_GREEN > YELLOW_T) ? MAX_GREEN : YELLOW_T;
  localparam int unsigned DUR_2 = (DUR_1 > ALLRED_T) ? DUR_1 : ALLRED_T;
  localparam int unsigned DUR_MAX = (DUR_2 > WALK_T) ? DUR_2 : WALK_T;
  localparam int unsigned TW = $clog2(DUR_MAX + 2);

  localparam logic [TW-1:0] T_MIN = TW'(MIN_GREEN);
  localparam logic [TW-1:0] T_MAX = TW'(MAX_GREEN);
  localparam logic [TW-1:0] T_YEL = TW'(YELLOW_T);
  localparam logic [TW-1:0] T_RED = TW'(ALLRED_T);
  localparam logic [TW-1:0] T_SAT = TW'(DUR_MAX);

  state_t        state, state_nxt;
  logic [TW-1:0] timer;
  logic [TW-1:0] e;
  logic          tick;
  logic          req_a, req_b;
  logic          ped_pend;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  assign e = timer + 1'b1;

`ifdef PED_REQ_EN
  localparam logic [TW-1:0] T_WALK = TW'(WALK_T);
  logic walk_to_b;

  // Pedestrian flag is sticky until the walk phase starts; walk_to_b remembers which green follows.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ped_pend  <= 1'b0;
      walk_to_b <= 1'b0;
      walk      <= 1'b0;
    end else begin
      walk <= (state_nxt == PED_WALK);
      if (state_nxt == PED_WALK && state != PED_WALK) begin
        ped_pend  <= 1'b0;
        walk_to_b <= (state == A_YELLOW);
      end else if (ped_req) begin
        ped_pend <= 1'b1;
      end
    end
  end
`else
  assign ped_pend = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    if (tick) begin
      case (state)
        INIT_RED: if (e >= T_RED) state_nxt = A_GREEN;
        A_GREEN:
          if (e >= T_MIN && (req_b || ped_pend) && (!traffic_A || e >= T_MAX))
            state_nxt = A_YELLOW;
        A_YELLOW:
          if (e >= T_YEL) begin
`ifdef PED_REQ_EN
            state_nxt = ped_pend ? PED_WALK : RED_AB;
`else
            state_nxt = RED_AB;
`endif
          end
        RED_AB: if (e >= T_RED) state_nxt = B_GREEN;
        B_GREEN:
          if (e >= T_MIN && (req_a || ped_pend) && (!traffic_B || e >= T_MAX))
            state_nxt = B_YELLOW;
        B_YELLOW:
          if (e >= T_YEL) begin
`ifdef PED_REQ_EN
            state_nxt = ped_pend ? PED_WALK : RED_BA;
`else
            state_nxt = RED_BA;
`endif
          end
        RED_BA: if (e >= T_RED) state_nxt = A_GREEN;
`ifdef PED_REQ_EN
        PED_WALK: if (e >= T_WALK) state_nxt = walk_to_b ? RED_AB : RED_BA;
`endif
        default: state_nxt = INIT_RED;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= INIT_RED;
      light_A <= LAMP_RED;
      light_B <= LAMP_RED;
      timer   <= '0;
      req_a   <= 1'b0;
      req_b   <= 1'b0;
    end else begin
      state   <= state_nxt;
      light_A <= lamp_a(state_nxt);
      light_B <= lamp_b(state_nxt);

      if (state_nxt != state) begin
        timer <= '0;
      end else if (tick && timer < T_SAT) begin
        timer <= timer + 1'b1;
      end

      // Entry into the served green wins over a sensor still asserted that cycle.
      if (state_nxt == A_GREEN && state != A_GREEN) begin
        req_a <= 1'b0;
      end else if (traffic_A && state != A_GREEN) begin
        req_a <= 1'b1;
      end

      if (state_nxt == B_GREEN && state != B_GREEN) begin
        req_b <= 1'b0;
      end else if (traffic_B && state != B_GREEN) begin
        req_b <= 1'b1;
      end
    end
  end

endmodule
